// File: rtl/sha256_req_arbiter.sv
// sha256_req_arbiter: shares one SHA256 core between two requesters, granting
// the core for a whole message in round-robin order and routing the digest back
// to the owning requester. A watchdog aborts a stalled digest.
module sha256_req_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DIG_WORDS  = 8,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0_valid,
   input  logic [DATA_WIDTH-1:0] req0_data,
   input  logic                  req0_last,
   output logic                  req0_ready,
   output logic                  dig0_valid,
   output logic [DATA_WIDTH-1:0] dig0_data,
   input  logic                  req1_valid,
   input  logic [DATA_WIDTH-1:0] req1_data,
   input  logic                  req1_last,
   output logic                  req1_ready,
   output logic                  dig1_valid,
   output logic [DATA_WIDTH-1:0] dig1_data,
   output logic                  core_dv_out,
   output logic [DATA_WIDTH-1:0] core_data_out,
   output logic                  core_last_out,
   input  logic                  core_ready_in,
   input  logic                  core_dig_valid_in,
   input  logic [DATA_WIDTH-1:0] core_dig_data_in,
   output logic                  owner_out,
   output logic                  busy_out,
   output logic                  err_out
);

   localparam int unsigned WCNT_W = 4;
   localparam int unsigned DCNT_W = $clog2(DIG_WORDS + 1);
   localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, STREAM, WAIT_DIG, RETURN} state_t;

   state_t                state;
   state_t                state_nxt;
   logic                  rr;
   logic [WCNT_W-1:0]     wcnt;
   logic [DCNT_W-1:0]     dcnt;
   logic [WDOG_W-1:0]     wdog;

   logic                  grant_c;
   logic                  own_valid_c;
   logic                  own_last_c;
   logic [DATA_WIDTH-1:0] own_data_c;
   logic                  xfer_c;
   logic                  dig_c;
   logic                  dig_done_c;
   logic                  wdog_exp_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state plus the combinational word path from owner to core
   always_comb begin
      state_nxt     = state;
      req0_ready    = 1'b0;
      req1_ready    = 1'b0;
      core_dv_out   = 1'b0;
      core_data_out = '0;
      core_last_out = 1'b0;
      xfer_c        = 1'b0;
      dig_c         = 1'b0;
      dig_done_c    = 1'b0;
      wdog_exp_c    = 1'b0;
      own_valid_c   = owner_out ? req1_valid : req0_valid;
      own_last_c    = owner_out ? req1_last  : req0_last;
      own_data_c    = owner_out ? req1_data  : req0_data;
      grant_c       = (req0_valid & req1_valid) ? rr : req1_valid;
      case (state)
         IDLE: begin
            if (req0_valid | req1_valid) state_nxt = STREAM;
         end
         STREAM: begin
            core_dv_out   = own_valid_c;
            core_data_out = own_data_c;
            core_last_out = own_last_c;
            req0_ready    = ~owner_out & core_ready_in;
            req1_ready    = owner_out & core_ready_in;
            xfer_c        = own_valid_c & core_ready_in;
            if (xfer_c & own_last_c) state_nxt = WAIT_DIG;
         end
         WAIT_DIG: begin
            dig_c      = core_dig_valid_in;
            dig_done_c = dig_c & (dcnt == DCNT_W'(DIG_WORDS - 1));
            wdog_exp_c = ~dig_c & (wdog == WDOG_W'(TIMEOUT - 1));
            if (dig_done_c | wdog_exp_c) state_nxt = RETURN;
         end
         RETURN: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Grant, counters, watchdog, sticky error and registered digest routing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_out  <= 1'b0;
         busy_out   <= 1'b0;
         err_out    <= 1'b0;
         rr         <= 1'b0;
         wcnt       <= '0;
         dcnt       <= '0;
         wdog       <= '0;
         dig0_valid <= 1'b0;
         dig0_data  <= '0;
         dig1_valid <= 1'b0;
         dig1_data  <= '0;
      end else begin
         dig0_valid <= 1'b0;
         dig0_data  <= '0;
         dig1_valid <= 1'b0;
         dig1_data  <= '0;
         if (core_dig_valid_in & (state != WAIT_DIG)) err_out <= 1'b1;
         case (state)
            IDLE: begin
               if (req0_valid | req1_valid) begin
                  owner_out <= grant_c;
                  busy_out  <= 1'b1;
               end
            end
            STREAM: begin
               if (xfer_c) begin
                  wcnt <= wcnt + WCNT_W'(1);
                  // a message must end on the 16th word of a 512-bit block
                  if (own_last_c && (wcnt != '1)) err_out <= 1'b1;
               end
            end
            WAIT_DIG: begin
               if (dig_c) begin
                  if (owner_out) begin
                     dig1_valid <= 1'b1;
                     dig1_data  <= core_dig_data_in;
                  end else begin
                     dig0_valid <= 1'b1;
                     dig0_data  <= core_dig_data_in;
                  end
                  dcnt <= dcnt + DCNT_W'(1);
                  wdog <= '0;
               end else begin
                  wdog <= wdog + WDOG_W'(1);
                  if (wdog_exp_c) err_out <= 1'b1;
               end
            end
            RETURN: begin
               rr       <= ~owner_out;
               busy_out <= 1'b0;
               wcnt     <= '0;
               dcnt     <= '0;
               wdog     <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/sha256_req_arbiter.md
Name: sha256_req_arbiter

Overview:
- Shares one SHA256 core between two message requesters (req0, req1), e.g. the UART packer path and an on-chip host path.
- Grants the core to one requester for a whole message and forwards that requester's 32-bit words to the core.
- Collects the 8-word digest from the core and routes it back to the owning requester only.
- Arbitration is round-robin at message granularity. A watchdog covers a stalled digest.

Parameters:
- DATA_WIDTH, 32, width of message and digest words.
- DIG_WORDS, 8, digest words returned per message.
- TIMEOUT, 1024, maximum cycles in WAIT_DIG before abort.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 word valid
- req0_data  in  DATA_WIDTH  requester 0 message word
- req0_last  in  1  requester 0 last word of message
- req0_ready  out  1  requester 0 word accepted when valid&ready
- dig0_valid  out  1  digest word valid to requester 0
- dig0_data  out  DATA_WIDTH  digest word to requester 0
- req1_valid, req1_data, req1_last, req1_ready, dig1_valid, dig1_data: identical set for requester 1
- core_dv_out  out  1  word valid to core
- core_data_out  out  DATA_WIDTH  word to core
- core_last_out  out  1  last word of message to core
- core_ready_in  in  1  core can accept a word
- core_dig_valid_in  in  1  core digest word valid (one word per pulse)
- core_dig_data_in  in  DATA_WIDTH  core digest word
- owner_out  out  1  index of current owner; valid while busy_out=1
- busy_out  out  1  core granted
- err_out  out  1  sticky protocol/timeout error, cleared only by reset

Behaviour:
- Reset values: all outputs 0, round-robin pointer rr=0, counters 0, state IDLE. Reset mid-operation aborts immediately. No digest is delivered for the interrupted message.
- FSM states: IDLE, STREAM, WAIT_DIG, RETURN.
- IDLE:
  - ready outputs are 0.
  - If exactly one reqN_valid is 1, grant N.
  - If both are 1, grant rr.
  - Registered: owner_out=N, busy_out=1, next state STREAM.
  - Grant latency is 1 cycle: no word transfers in IDLE.
- STREAM:
  - core_dv_out = owner valid; core_data_out / core_last_out = owner data / last.
  - owner ready = core_ready_in; non-owner ready = 0.
  - Transfer occurs when core_dv_out & core_ready_in.
  - A 4-bit word counter wcnt increments on each transfer and wraps at 16.
  - A transfer with last=1 moves to WAIT_DIG.
  - If last=1 arrives with wcnt != 15 (message not a whole number of 512-bit blocks), set err_out. The transfer still completes and the FSM still moves to WAIT_DIG.
- WAIT_DIG:
  - All ready outputs 0, core_dv_out=0.
  - Each core_dig_valid_in is registered to digN_valid/digN_data of the owner, 1-cycle latency. The non-owner's dig outputs stay 0.
  - dcnt counts digest words. After the DIG_WORDS-th word, go to RETURN.
  - A watchdog counts cycles since entering WAIT_DIG and resets on each digest word.
  - If the watchdog reaches TIMEOUT: set err_out, go to RETURN, deliver no further words.
- RETURN:
  - One cycle, so the last registered digest word drains.
  - rr = ~owner; busy_out=0; clear wcnt, dcnt and watchdog; go to IDLE.
- A core_dig_valid_in outside WAIT_DIG is ignored and sets err_out.
- Non-owner valid held high during a grant is not dropped: it is stalled (ready=0) and served at the next IDLE.
- No back-to-back grant without passing IDLE: minimum 1-cycle gap between messages.

Test Plan:
- Single requester: req0 sends 16 words 0x00000000..0x0000000F, last on word 15, core_ready_in=1; core returns 8 digest words 0xA0..0xA7 → core sees the 16 words in order; dig0 delivers 0xA0..0xA7 each one cycle after the core pulse; dig1 stays 0; err_out=0.
- Contention: both valid in IDLE after reset → req0 granted first (rr=0). After its digest, req1 granted. Then both valid again → req0 granted (round-robin alternation).
- Backpressure: core_ready_in toggles 1,0,1,0 during STREAM → owner ready mirrors it; exactly 16 transfers; no word duplicated or lost.
- Bad length: req1 asserts last on its 10th word → err_out=1 from the next cycle; FSM enters WAIT_DIG and the digest still returns to req1.
- Timeout: after the message, core delivers 3 digest words then stops, with TIMEOUT=16 → err_out=1 16 cycles after the 3rd word; busy_out falls; next request is granted normally.
- Reset mid-STREAM at word 7 → all outputs 0 asynchronously; after release, a fresh 16-word message completes correctly.
